// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions: datapath word width, memory sequencer state type and
// the default SRAM wait-state count used by the bus interface.
package lc3_pkg;

   localparam int WORD_W              = 16;
   localparam int DEFAULT_WAIT_STATES = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } mem_state_t;

   // Bits needed to hold 0..max_count; never narrower than one bit.
   function automatic int cnt_width(input int max_count);
      return (max_count < 2) ? 1 : $clog2(max_count + 1);
   endfunction

endpackage

// File: rtl/wait_counter.sv
// Parameterised up-counter with synchronous clear, enable and a terminal-count
// flag; it holds at TERM so a late enable can never wrap it.
module wait_counter #(
   parameter int WIDTH = 2,
   parameter int TERM  = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   assign tc_o = (cnt_q == WIDTH'(TERM));

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && !tc_o) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mem_bus_interface.sv
// LC-3 memory bus interface: latches MAR/MDR from the shared datapath bus and
// sequences the SRAM CE/OE/WE strobes with a programmable number of wait states.
module mem_bus_interface
   import lc3_pkg::*;
#(
   parameter int WAIT_STATES = DEFAULT_WAIT_STATES,
   parameter int ADDR_W      = 20
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic [WORD_W-1:0] Datapath_in,
   input  logic              LD_MAR,
   input  logic              LD_MDR,
   input  logic              MIO_EN,
   input  logic              Mem_req,
   input  logic              R_W,
   input  logic [WORD_W-1:0] Mem_Data_in,
   output logic [WORD_W-1:0] MAR,
   output logic [WORD_W-1:0] MDR,
   output logic              R,
   output logic              Busy,
   output logic [ADDR_W-1:0] Mem_Addr,
   output logic [WORD_W-1:0] Mem_Data_out,
   output logic              Mem_Data_oe,
   output logic              Mem_CE_n,
   output logic              Mem_OE_n,
   output logic              Mem_WE_n
);

   localparam int CNT_W = cnt_width(WAIT_STATES);

   mem_state_t        state_q, state_d;
   logic [WORD_W-1:0] mar_q, mar_d;
   logic [WORD_W-1:0] mdr_q, mdr_d;
   logic              wr_q, wr_d;
   logic              cnt_tc;
   logic              in_access;

   // The counter idles at zero and only runs while the strobes are active.
   wait_counter #(
      .WIDTH (CNT_W),
      .TERM  (WAIT_STATES)
   ) u_wait_counter (
      .clk   (Clk),
      .rst_n (Reset_n),
      .clr_i (state_q == IDLE),
      .en_i  (state_q == ACCESS),
      .tc_o  (cnt_tc)
   );

   always_comb begin
      // NOTE: every next-state value gets a default first, so no path can infer a latch.
      state_d = state_q;
      mar_d   = mar_q;
      mdr_d   = mdr_q;
      wr_d    = wr_q;
      case (state_q)
         IDLE: begin
            if (LD_MAR) mar_d = Datapath_in;
            if (LD_MDR && !MIO_EN) mdr_d = Datapath_in;
            if (Mem_req) begin
               wr_d    = R_W;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            if (cnt_tc) begin
               if (!wr_q) mdr_d = Mem_Data_in;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: reset is asynchronous so an access in flight is aborted without waiting for a clock.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= IDLE;
         mar_q   <= '0;
         mdr_q   <= '0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         mar_q   <= mar_d;
         mdr_q   <= mdr_d;
         wr_q    <= wr_d;
      end
   end

   // Strobes decode from registered state only; the request cycle itself drives nothing.
   assign in_access    = (state_q == ACCESS);
   assign Mem_CE_n     = !in_access;
   assign Mem_OE_n     = !(in_access && !wr_q);
   assign Mem_WE_n     = !(in_access && wr_q);
   assign Mem_Data_oe  = in_access && wr_q;
   assign R            = (state_q == DONE);
   assign Busy         = (state_q != IDLE);

   assign MAR          = mar_q;
   assign MDR          = mdr_q;
   assign Mem_Addr     = ADDR_W'(mar_q);
   assign Mem_Data_out = mdr_q;

endmodule

// File: tb/tb_mem_bus_interface.sv
// Bench for mem_bus_interface: a WAIT_STATES=2 and a WAIT_STATES=0 build share one
// directed stimulus stream and are checked against a cycle-indexed access model.
module tb_mem_bus_interface;

   localparam int NDUT = 2;
   localparam int WS_A = 2;
   localparam int WS_B = 0;

   logic        Clk         = 1'b0;
   logic        Reset_n     = 1'b0;
   logic [15:0] Datapath_in = '0;
   logic        LD_MAR      = 1'b0;
   logic        LD_MDR      = 1'b0;
   logic        MIO_EN      = 1'b0;
   logic        Mem_req     = 1'b0;
   logic        R_W         = 1'b0;
   logic [15:0] Mem_Data_in = '0;

   logic [15:0] mar  [NDUT];
   logic [15:0] mdr  [NDUT];
   logic [15:0] dout [NDUT];
   logic [19:0] addr [NDUT];
   logic        r    [NDUT];
   logic        busy [NDUT];
   logic        doe  [NDUT];
   logic        ce_n [NDUT];
   logic        oe_n [NDUT];
   logic        we_n [NDUT];

   always #5 Clk = ~Clk;

   mem_bus_interface #(.WAIT_STATES(WS_A), .ADDR_W(20)) u_ws2 (
      .Clk(Clk), .Reset_n(Reset_n), .Datapath_in(Datapath_in),
      .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .MIO_EN(MIO_EN), .Mem_req(Mem_req),
      .R_W(R_W), .Mem_Data_in(Mem_Data_in),
      .MAR(mar[0]), .MDR(mdr[0]), .R(r[0]), .Busy(busy[0]), .Mem_Addr(addr[0]),
      .Mem_Data_out(dout[0]), .Mem_Data_oe(doe[0]),
      .Mem_CE_n(ce_n[0]), .Mem_OE_n(oe_n[0]), .Mem_WE_n(we_n[0])
   );

   mem_bus_interface #(.WAIT_STATES(WS_B), .ADDR_W(20)) u_ws0 (
      .Clk(Clk), .Reset_n(Reset_n), .Datapath_in(Datapath_in),
      .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .MIO_EN(MIO_EN), .Mem_req(Mem_req),
      .R_W(R_W), .Mem_Data_in(Mem_Data_in),
      .MAR(mar[1]), .MDR(mdr[1]), .R(r[1]), .Busy(busy[1]), .Mem_Addr(addr[1]),
      .Mem_Data_out(dout[1]), .Mem_Data_oe(doe[1]),
      .Mem_CE_n(ce_n[1]), .Mem_OE_n(oe_n[1]), .Mem_WE_n(we_n[1])
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s @%0t actual=%h required=%h", name, $time, act, exp);
      end
   endtask

   function automatic int ws_of(input int i);
      return (i == 0) ? WS_A : WS_B;
   endfunction

   // Model: m_k = -1 when idle, 0..WS = index of the strobed cycle, WS+1 = ready cycle.
   int          m_k   [NDUT] = '{-1, -1};
   logic [15:0] m_mar [NDUT] = '{16'h0, 16'h0};
   logic [15:0] m_mdr [NDUT] = '{16'h0, 16'h0};
   logic        m_wr  [NDUT] = '{1'b0, 1'b0};

   always @(posedge Clk or negedge Reset_n) begin
      for (int i = 0; i < NDUT; i++) begin
         if (!Reset_n) begin
            m_k[i]   <= -1;
            m_mar[i] <= '0;
            m_mdr[i] <= '0;
            m_wr[i]  <= 1'b0;
         end else if (m_k[i] < 0) begin
            if (LD_MAR) m_mar[i] <= Datapath_in;
            if (LD_MDR && !MIO_EN) m_mdr[i] <= Datapath_in;
            if (Mem_req) begin
               m_wr[i] <= R_W;
               m_k[i]  <= 0;
            end
         end else if (m_k[i] <= ws_of(i)) begin
            if (m_k[i] == ws_of(i) && !m_wr[i]) m_mdr[i] <= Mem_Data_in;
            m_k[i] <= m_k[i] + 1;
         end else begin
            m_k[i] <= -1;
         end
      end
   end

   // Every-cycle comparison of all outputs of both builds against the model.
   always @(negedge Clk) begin
      logic acc, dn;
      for (int i = 0; i < NDUT; i++) begin
         acc = (m_k[i] >= 0) && (m_k[i] <= ws_of(i));
         dn  = (m_k[i] == ws_of(i) + 1);
         check($sformatf("cycle_dut%0d", i),
               {mar[i], mdr[i], r[i], busy[i], addr[i], dout[i],
                doe[i], ce_n[i], oe_n[i], we_n[i]},
               {m_mar[i], m_mdr[i], dn, acc | dn, {4'h0, m_mar[i]}, m_mdr[i],
                acc & m_wr[i], !acc, !(acc & !m_wr[i]), !(acc & m_wr[i])});
      end
   end

   // Per-access observations for the hand-computed expectations.
   int r_first  [NDUT];
   int r_cnt    [NDUT];
   int oe_cyc   [NDUT];
   int we_cyc   [NDUT];
   int doe_cyc  [NDUT];
   int addr_bad [NDUT];
   int dout_bad [NDUT];

   task automatic tick();
      @(negedge Clk);
      LD_MAR  = 1'b0;
      LD_MDR  = 1'b0;
      Mem_req = 1'b0;
   endtask

   // Called at the first falling edge after the request edge (cycle 1).
   // mode 1: bus loads and a request while busy; mode 2: second request in cycle 3.
   task automatic observe(input int n, input int mode, input logic [19:0] exp_addr,
                          input logic [15:0] exp_dout);
      for (int i = 0; i < NDUT; i++) begin
         r_first[i] = 0; r_cnt[i] = 0; oe_cyc[i] = 0; we_cyc[i] = 0;
         doe_cyc[i] = 0; addr_bad[i] = 0; dout_bad[i] = 0;
      end
      for (int k = 1; k <= n; k++) begin
         for (int i = 0; i < NDUT; i++) begin
            if (r[i]) begin
               r_cnt[i]++;
               if (r_first[i] == 0) r_first[i] = k;
            end
            if (!oe_n[i]) oe_cyc[i]++;
            if (!we_n[i]) we_cyc[i]++;
            if (doe[i]) doe_cyc[i]++;
            if (!ce_n[i] && addr[i] != exp_addr) addr_bad[i]++;
            if (doe[i] && dout[i] != exp_dout) dout_bad[i]++;
         end
         LD_MAR = 1'b0; LD_MDR = 1'b0; Mem_req = 1'b0;
         if (mode == 1 && (k == 1 || k == 2)) begin
            Datapath_in = 16'h0042; LD_MAR = 1'b1; LD_MDR = 1'b1;
            MIO_EN = 1'b0; Mem_req = 1'b1; R_W = 1'b1;
         end
         if (mode == 2 && k == 3) begin
            Mem_req = 1'b1; R_W = 1'b0;
         end
         @(negedge Clk);
      end
   endtask

   initial begin
      // Reset values
      repeat (3) @(negedge Clk);
      for (int i = 0; i < NDUT; i++)
         check($sformatf("reset_state_dut%0d", i),
               {mar[i], mdr[i], r[i], busy[i], doe[i], ce_n[i], oe_n[i], we_n[i]},
               {16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1});
      Reset_n = 1'b1;
      tick();

      // Read from 0x3000 returning 0xBEEF
      Datapath_in = 16'h3000; LD_MAR = 1'b1; tick();
      Mem_Data_in = 16'hBEEF; R_W = 1'b0; Mem_req = 1'b1; tick();
      observe(8, 0, 20'h03000, 16'h0000);
      check("read_r_cycle_ws2", r_first[0], 4);
      check("read_r_cycle_ws0", r_first[1], 2);
      check("read_oe_cycles_ws2", oe_cyc[0], 3);
      check("read_oe_cycles_ws0", oe_cyc[1], 1);
      check("read_addr_bad", addr_bad[0] + addr_bad[1], 0);
      check("read_mdr_ws2", mdr[0], 16'hBEEF);
      check("read_mdr_ws0", mdr[1], 16'hBEEF);
      check("read_r_pulses", r_cnt[0] + r_cnt[1], 2);

      // Write 0x1234 to 0xFFFF; SRAM data pins hold a different value
      Mem_Data_in = 16'h5555;
      Datapath_in = 16'h1234; LD_MDR = 1'b1; MIO_EN = 1'b0; tick();
      Datapath_in = 16'hFFFF; LD_MAR = 1'b1; tick();
      R_W = 1'b1; Mem_req = 1'b1; tick();
      observe(8, 0, 20'h0FFFF, 16'h1234);
      check("write_we_cycles_ws2", we_cyc[0], 3);
      check("write_we_cycles_ws0", we_cyc[1], 1);
      check("write_oe_data_cycles_ws2", doe_cyc[0], 3);
      check("write_read_strobe", oe_cyc[0] + oe_cyc[1], 0);
      check("write_addr_bad", addr_bad[0] + addr_bad[1], 0);
      check("write_dout_bad", dout_bad[0] + dout_bad[1], 0);
      check("write_mdr_kept_ws2", mdr[0], 16'h1234);
      check("write_mdr_kept_ws0", mdr[1], 16'h1234);

      // Loads and requests while busy are ignored
      Mem_Data_in = 16'hA5A5; R_W = 1'b0; Mem_req = 1'b1; tick();
      observe(10, 1, 20'h0FFFF, 16'h0000);
      check("busy_mar_ws2", mar[0], 16'hFFFF);
      check("busy_mar_ws0", mar[1], 16'hFFFF);
      check("busy_mdr_ws2", mdr[0], 16'hA5A5);
      check("busy_mdr_ws0", mdr[1], 16'hA5A5);
      check("busy_one_r_ws2", r_cnt[0], 1);
      check("busy_one_r_ws0", r_cnt[1], 1);
      check("busy_no_write", we_cyc[0] + we_cyc[1], 0);
      check("busy_idle_after", {busy[0], busy[1]}, 2'b00);

      // LD_MDR with MIO_EN=1 does not touch MDR
      Datapath_in = 16'hDEAD; LD_MDR = 1'b1; MIO_EN = 1'b1; tick();
      MIO_EN = 1'b0; tick();
      check("mio_mdr_hold", mdr[0], 16'hA5A5);

      // Same-cycle LD_MAR + read request
      Mem_Data_in = 16'h0F0F; Datapath_in = 16'h0010;
      LD_MAR = 1'b1; R_W = 1'b0; Mem_req = 1'b1; tick();
      observe(8, 0, 20'h00010, 16'h0000);
      check("same_cycle_addr_bad", addr_bad[0] + addr_bad[1], 0);
      check("same_cycle_oe_ws2", oe_cyc[0], 3);
      check("same_cycle_mdr", mdr[0], 16'h0F0F);

      // Same-cycle LD_MDR + write request
      Datapath_in = 16'h0077; LD_MDR = 1'b1; MIO_EN = 1'b0;
      R_W = 1'b1; Mem_req = 1'b1; tick();
      observe(8, 0, 20'h00010, 16'h0077);
      check("same_cycle_wr_dout_bad", dout_bad[0] + dout_bad[1], 0);
      check("same_cycle_wr_doe_ws2", doe_cyc[0], 3);
      check("same_cycle_wr_doe_ws0", doe_cyc[1], 1);

      // Back-to-back request right after R on the zero-wait build
      Mem_Data_in = 16'h1111; R_W = 1'b0; Mem_req = 1'b1; tick();
      observe(10, 2, 20'h00010, 16'h0000);
      check("b2b_r_pulses_ws0", r_cnt[1], 2);
      check("b2b_r_pulses_ws2", r_cnt[0], 1);
      check("b2b_oe_cycles_ws0", oe_cyc[1], 2);
      check("b2b_mdr_ws0", mdr[1], 16'h1111);

      // Reset in the middle of a write access
      Datapath_in = 16'h9999; LD_MDR = 1'b1; MIO_EN = 1'b0; tick();
      R_W = 1'b1; Mem_req = 1'b1; tick();
      check("pre_reset_in_access", {busy[0], we_n[0]}, 2'b10);
      @(posedge Clk);
      #2 Reset_n = 1'b0;
      #1;
      check("async_reset_ws2",
            {mar[0], mdr[0], r[0], busy[0], doe[0], ce_n[0], oe_n[0], we_n[0]},
            {16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1});
      @(negedge Clk);
      @(negedge Clk);
      Reset_n = 1'b1;
      observe(8, 0, 20'h00000, 16'h0000);
      check("reset_no_r", r_cnt[0] + r_cnt[1], 0);
      check("reset_no_strobe", we_cyc[0] + we_cyc[1] + oe_cyc[0] + oe_cyc[1], 0);
      check("reset_mdr_cleared", mdr[0], 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
